// File: rtl/cs_useq_pkg.sv
// cs_useq_pkg: sequencing opcodes and FSM state encoding shared by the
// microsequencer, its return stack and its bus interface.
package cs_useq_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_INC    = 3'b000;
  localparam logic [OP_W-1:0] OP_JMP    = 3'b001;
  localparam logic [OP_W-1:0] OP_CJMP   = 3'b010;
  localparam logic [OP_W-1:0] OP_CALL   = 3'b011;
  localparam logic [OP_W-1:0] OP_RET    = 3'b100;
  localparam logic [OP_W-1:0] OP_HOLD   = 3'b101;
  localparam logic [OP_W-1:0] OP_LDLOOP = 3'b110;
  localparam logic [OP_W-1:0] OP_DJNZ   = 3'b111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

endpackage : cs_useq_pkg

// File: rtl/cs_useq_if.sv
// cs_useq_if: microinstruction-side inputs and control-store address /
// status outputs of the microsequencer.
//   master: datapath / decoder side driving opcode, condition and acknowledge
//   slave : the sequencer itself
interface cs_useq_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned SP_W   = 3
);
  import cs_useq_pkg::*;

  logic              CS_USEQ_ACK;
  logic [OP_W-1:0]   CS_USEQ_OP;
  logic              CS_USEQ_COND;
  logic [ADDR_W-1:0] CS_USEQ_JUMP_ADDR;
  logic              CS_USEQ_CLEAR;
  logic [ADDR_W-1:0] CS_USEQ_data_OutBUS;
  logic [SP_W-1:0]   CS_USEQ_SP_OutBUS;
  logic              CS_USEQ_FAULT;
  logic              CS_USEQ_OVF;
  logic              CS_USEQ_UNF;

  modport master (
    output CS_USEQ_ACK, CS_USEQ_OP, CS_USEQ_COND, CS_USEQ_JUMP_ADDR, CS_USEQ_CLEAR,
    input  CS_USEQ_data_OutBUS, CS_USEQ_SP_OutBUS, CS_USEQ_FAULT, CS_USEQ_OVF, CS_USEQ_UNF
  );

  modport slave (
    input  CS_USEQ_ACK, CS_USEQ_OP, CS_USEQ_COND, CS_USEQ_JUMP_ADDR, CS_USEQ_CLEAR,
    output CS_USEQ_data_OutBUS, CS_USEQ_SP_OutBUS, CS_USEQ_FAULT, CS_USEQ_OVF, CS_USEQ_UNF
  );

endinterface : cs_useq_if

// File: rtl/cs_useq_stack.sv
// cs_useq_stack: return-address LIFO with occupancy counter. Push and pop are
// ignored when full / empty respectively; the caller decides what that means.
module cs_useq_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 11,
  parameter int unsigned SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    push_data,
  output logic            full_c,
  output logic            empty_c,
  output logic [W-1:0]    top_c,
  output logic [SP_W-1:0] sp
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];

  assign full_c  = (sp == SP_W'(DEPTH));
  assign empty_c = (sp == '0);
  // Entry below the pointer; only meaningful when not empty.
  assign top_c   = mem[IDX_W'(sp - SP_W'(1))];

  // Storage and pointer update; clear only rewinds the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      mem <= '{default: '0};
    end else if (clr) begin
      sp <= '0;
    end else if (push && !full_c) begin
      mem[IDX_W'(sp)] <= push_data;
      sp              <= sp + SP_W'(1);
    end else if (pop && !empty_c) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule : cs_useq_stack

// File: rtl/cs_useq.sv
// cs_useq: control-store microsequencer. Computes the next micro-PC from the
// sequencing opcode (increment, jump, conditional jump, call/return, hold) and
// advances only on acknowledge. Stack overflow/underflow parks it in FAULT
// until CLEAR.
// Optional build macro CS_USEQ_LOOP_EN adds a LOOP_W-bit loop counter driving
// opcodes LDLOOP and DJNZ; without it those opcodes behave as INC.
module cs_useq
  import cs_useq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0,
  parameter int unsigned LOOP_W      = 8
) (
  input  logic      CS_USEQ_CLOCK_50,
  input  logic      CS_USEQ_RESET,
  cs_useq_if.slave  cs_bus
);

  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

  // Elaboration-time parameter sanity.
  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("cs_useq: STACK_DEPTH must be at least 1");
  end
  if (LOOP_W < 1 || LOOP_W > ADDR_W) begin : g_bad_loop_w
    $error("cs_useq: LOOP_W must be in 1..ADDR_W");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] upc_inc;
  logic              stk_push, stk_pop, stk_clr;
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;
  logic [SP_W-1:0]   stk_sp;

`ifdef CS_USEQ_LOOP_EN
  logic [LOOP_W-1:0] loop_q, loop_d;
`endif

  assign upc_inc = upc_q + ADDR_W'(1);

  cs_useq_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W),
    .SP_W  (SP_W)
  ) u_stack (
    .clk       (CS_USEQ_CLOCK_50),
    .rst_n     (CS_USEQ_RESET),
    .clr       (stk_clr),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (upc_inc),
    .full_c    (stk_full),
    .empty_c   (stk_empty),
    .top_c     (stk_top),
    .sp        (stk_sp)
  );

  // State, micro-PC and sticky flag registers.
  always_ff @(posedge CS_USEQ_CLOCK_50 or negedge CS_USEQ_RESET) begin
    if (!CS_USEQ_RESET) begin
      state_q <= ST_RUN;
      upc_q   <= ADDR_W'(RESET_ADDR);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef CS_USEQ_LOOP_EN
  // Hardware loop counter register.
  always_ff @(posedge CS_USEQ_CLOCK_50 or negedge CS_USEQ_RESET) begin
    if (!CS_USEQ_RESET) begin
      loop_q <= '0;
    end else begin
      loop_q <= loop_d;
    end
  end
`endif

  // Next-address mux, stack control and RUN/FAULT transitions.
  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
`ifdef CS_USEQ_LOOP_EN
    loop_d   = loop_q;
`endif

    case (state_q)
      ST_RUN: begin
        if (cs_bus.CS_USEQ_ACK) begin
          case (cs_bus.CS_USEQ_OP)
            OP_INC:  upc_d = upc_inc;
            OP_JMP:  upc_d = cs_bus.CS_USEQ_JUMP_ADDR;
            OP_CJMP: upc_d = cs_bus.CS_USEQ_COND ? cs_bus.CS_USEQ_JUMP_ADDR : upc_inc;
            OP_CALL: begin
              if (stk_full) begin
                ovf_d   = 1'b1;
                state_d = ST_FAULT;
              end else begin
                stk_push = 1'b1;
                upc_d    = cs_bus.CS_USEQ_JUMP_ADDR;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                unf_d   = 1'b1;
                state_d = ST_FAULT;
              end else begin
                stk_pop = 1'b1;
                upc_d   = stk_top;
              end
            end
            OP_HOLD: upc_d = upc_q;
`ifdef CS_USEQ_LOOP_EN
            OP_LDLOOP: begin
              loop_d = LOOP_W'(cs_bus.CS_USEQ_JUMP_ADDR);
              upc_d  = upc_inc;
            end
            OP_DJNZ: begin
              if (loop_q != '0) begin
                loop_d = loop_q - LOOP_W'(1);
                upc_d  = cs_bus.CS_USEQ_JUMP_ADDR;
              end else begin
                upc_d  = upc_inc;
              end
            end
`endif
            default: upc_d = upc_inc;
          endcase
        end
      end
      ST_FAULT: begin
        if (cs_bus.CS_USEQ_CLEAR) begin
          state_d = ST_RUN;
          upc_d   = ADDR_W'(RESET_ADDR);
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          stk_clr = 1'b1;
`ifdef CS_USEQ_LOOP_EN
          loop_d  = '0;
`endif
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign cs_bus.CS_USEQ_data_OutBUS = upc_q;
  assign cs_bus.CS_USEQ_SP_OutBUS   = stk_sp;
  assign cs_bus.CS_USEQ_FAULT       = (state_q == ST_FAULT);
  assign cs_bus.CS_USEQ_OVF         = ovf_q;
  assign cs_bus.CS_USEQ_UNF         = unf_q;

endmodule : cs_useq

// File: tb/tb_cs_useq.sv
// tb_cs_useq: directed and randomized checks of cs_useq against a queue-based
// behavioural model of the sequencing rules.
module tb_cs_useq;
  import cs_useq_pkg::*;

  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned SP_W       = $clog2(DEPTH + 1);
  localparam int unsigned RESET_ADDR = 0;
  localparam int unsigned LOOP_W     = 8;
  localparam int          AMASK      = (1 << ADDR_W) - 1;

  logic clk;
  logic rst_n;

  cs_useq_if #(.ADDR_W(ADDR_W), .SP_W(SP_W)) bus ();

  cs_useq #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (DEPTH),
    .RESET_ADDR  (RESET_ADDR),
    .LOOP_W      (LOOP_W)
  ) dut (
    .CS_USEQ_CLOCK_50 (clk),
    .CS_USEQ_RESET    (rst_n),
    .cs_bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int m_upc;
  int m_stack[$];
  bit m_fault, m_ovf, m_unf;
  int m_loop;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".upc"},   32'(bus.CS_USEQ_data_OutBUS), 32'(m_upc));
    chk({tag, ".sp"},    32'(bus.CS_USEQ_SP_OutBUS),   32'(m_stack.size()));
    chk({tag, ".fault"}, 32'(bus.CS_USEQ_FAULT),       32'(m_fault));
    chk({tag, ".ovf"},   32'(bus.CS_USEQ_OVF),         32'(m_ovf));
    chk({tag, ".unf"},   32'(bus.CS_USEQ_UNF),         32'(m_unf));
  endtask

  task automatic model_reset();
    m_upc   = RESET_ADDR;
    m_stack.delete();
    m_fault = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_loop  = 0;
  endtask

  task automatic model_step(input bit a, input int o, input bit c, input int ja, input bit cl);
    if (m_fault) begin
      if (cl) model_reset();
    end else if (a) begin
      case (o)
        0: m_upc = (m_upc + 1) & AMASK;
        1: m_upc = ja;
        2: m_upc = c ? ja : ((m_upc + 1) & AMASK);
        3: begin
          if (m_stack.size() == DEPTH) begin
            m_ovf = 1; m_fault = 1;
          end else begin
            m_stack.push_back((m_upc + 1) & AMASK);
            m_upc = ja;
          end
        end
        4: begin
          if (m_stack.size() == 0) begin
            m_unf = 1; m_fault = 1;
          end else begin
            m_upc = m_stack.pop_back();
          end
        end
        5: ;
`ifdef CS_USEQ_LOOP_EN
        6: begin
          m_loop = ja & ((1 << LOOP_W) - 1);
          m_upc  = (m_upc + 1) & AMASK;
        end
        7: begin
          if (m_loop != 0) begin
            m_loop = m_loop - 1;
            m_upc  = ja;
          end else begin
            m_upc = (m_upc + 1) & AMASK;
          end
        end
`endif
        default: m_upc = (m_upc + 1) & AMASK;
      endcase
    end
  endtask

  // Drive one microinstruction slot, advance the model, check after the edge.
  task automatic step(input string tag, input bit a, input int o, input bit c,
                      input int ja, input bit cl);
    bus.CS_USEQ_ACK       = a;
    bus.CS_USEQ_OP        = 3'(o);
    bus.CS_USEQ_COND      = c;
    bus.CS_USEQ_JUMP_ADDR = ADDR_W'(ja);
    bus.CS_USEQ_CLEAR     = cl;
    model_step(a, o, c, ja, cl);
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus.CS_USEQ_ACK       = 1'b0;
    bus.CS_USEQ_OP        = '0;
    bus.CS_USEQ_COND      = 1'b0;
    bus.CS_USEQ_JUMP_ADDR = '0;
    bus.CS_USEQ_CLEAR     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst_n = 1'b1;

    // Sequential increments from reset
    for (int i = 0; i < 3; i++) step("inc", 1, 0, 0, 0, 0);
    chk("inc3_const", 32'(bus.CS_USEQ_data_OutBUS), 32'd3);

    // Wrap at all-ones, then hold with ACK low
    step("jmp7ff", 1, 1, 0, 'h7FF, 0);
    step("wrap", 1, 0, 0, 0, 0);
    chk("wrap_const", 32'(bus.CS_USEQ_data_OutBUS), 32'd0);
    for (int i = 0; i < 5; i++) step("noack", 0, int'($urandom_range(0, 7)), 1, 'h123, 0);

    // Conditional jump both ways
    step("cjmp_nt", 1, 2, 0, 'h100, 0);
    step("cjmp_t", 1, 2, 1, 'h100, 0);
    chk("cjmp_const", 32'(bus.CS_USEQ_data_OutBUS), 32'h100);

    // Nested call / return
    step("jmp010", 1, 1, 0, 'h010, 0);
    step("call1", 1, 3, 0, 'h200, 0);
    step("inc201", 1, 0, 0, 0, 0);
    step("call2", 1, 3, 0, 'h300, 0);
    step("ret1", 1, 4, 0, 0, 0);
    chk("ret1_const", 32'(bus.CS_USEQ_data_OutBUS), 32'h202);
    step("ret2", 1, 4, 0, 0, 0);
    chk("ret2_const", 32'(bus.CS_USEQ_data_OutBUS), 32'h011);

    // Overflow on fifth call; FAULT ignores ops; CLEAR in RUN is inert
    for (int i = 0; i < 5; i++) step("call_ovf", 1, 3, 0, 'h400 + i * 16, 0);
    chk("ovf_const", 32'(bus.CS_USEQ_OVF), 32'd1);
    step("fault_ign", 1, 1, 1, 'h555, 0);
    step("fault_clr", 1, 0, 0, 0, 1);
    step("run_clr", 1, 0, 0, 0, 1);
    step("jmp_to0", 1, 1, 0, 0, 0);
    step("ret_unf", 1, 4, 0, 0, 0);
    chk("unf_const", 32'(bus.CS_USEQ_UNF), 32'd1);
    step("unf_clr", 0, 0, 0, 0, 1);

    // Loop ops (INC when the loop feature is absent)
    step("jmp04f", 1, 1, 0, 'h04F, 0);
    step("ldloop", 1, 6, 0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      step("loop_inc", 1, 0, 0, 0, 0);
      if (m_upc == 'h051) step("djnz", 1, 7, 0, 'h050, 0);
    end
    step("djnz_x", 1, 7, 0, 'h050, 0);

    // Randomized operation against the model
    for (int i = 0; i < 400; i++) begin
      bit a, c, cl;
      int o, ja;
      a  = ($urandom_range(0, 3) != 0);
      o  = int'($urandom_range(0, 7));
      c  = 1'($urandom);
      ja = int'($urandom_range(0, AMASK));
      cl = m_fault ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      step("rand", a, o, c, ja, cl);
    end

    // Asynchronous reset in the middle of a cycle
    step("pre_rst_clr", 0, 0, 0, 0, 1);
    step("pre_rst_call", 1, 3, 0, 'h2AA, 0);
    bus.CS_USEQ_ACK = 1'b1;
    bus.CS_USEQ_OP  = OP_INC;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk);
    #1;
    chk_all("rst_held");
    rst_n = 1'b1;
    step("post_rst", 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cs_useq
